// File: rtl/pipeline4_pkg.sv
// Shared widths, opcode encodings and helpers for the memory/writeback stage.
package pipeline4_pkg;
    localparam int DATA_WIDTH     = 16;
    localparam int MEM_WIDTH      = 16;
    localparam int PC_WIDTH       = 16;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int CTRL_WIDTH     = 6;
    localparam int MEM_TIMEOUT    = 15;
    localparam int CNT_WIDTH      = $clog2(MEM_TIMEOUT + 1);

    localparam logic [CTRL_WIDTH-1:0] OP_NOP    = 6'h00;
    localparam logic [CTRL_WIDTH-1:0] OP_ADD    = 6'h01;
    localparam logic [CTRL_WIDTH-1:0] OP_SUB    = 6'h02;
    localparam logic [CTRL_WIDTH-1:0] OP_AND    = 6'h03;
    localparam logic [CTRL_WIDTH-1:0] OP_OR     = 6'h04;
    localparam logic [CTRL_WIDTH-1:0] OP_XOR    = 6'h05;
    localparam logic [CTRL_WIDTH-1:0] OP_LW     = 6'h10;
    localparam logic [CTRL_WIDTH-1:0] OP_LW_IMM = 6'h11;
    localparam logic [CTRL_WIDTH-1:0] OP_SW     = 6'h12;
    localparam logic [CTRL_WIDTH-1:0] OP_JR     = 6'h13;
    localparam logic [CTRL_WIDTH-1:0] OP_JPC    = 6'h14;
    localparam logic [CTRL_WIDTH-1:0] OP_BRFL   = 6'h15;
    localparam logic [CTRL_WIDTH-1:0] OP_CALL   = 6'h16;
    localparam logic [CTRL_WIDTH-1:0] OP_RET    = 6'h17;

    // Everything that is not a memory access, jump/branch or NOP produces a register result.
    function automatic logic op_writes_rf(input logic [CTRL_WIDTH-1:0] op);
        case (op)
            OP_LW, OP_SW, OP_JR, OP_JPC, OP_BRFL, OP_RET, OP_NOP: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/pipeline4_mem_port_fsm.sv
// Data-memory req/ack handshake with timeout counter and sticky error flag.
module mem_port_fsm
    import pipeline4_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  start_wr,
    input  logic [MEM_WIDTH-1:0]  start_addr,
    input  logic [DATA_WIDTH-1:0] start_wdata,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [MEM_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_err
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 timeout;

    // An ack on the final WAIT cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_WAIT);

    always_ff @(posedge clk_in) begin
        if (!RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (start) begin
                    mem_req  <= 1'b1;
                    mem_wr   <= start_wr;
                    mem_addr <= start_addr;
                    if (start_wr) mem_wdata <= start_wdata;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (done || timeout) mem_req <= 1'b0;
                if (timeout) mem_err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/pipeline4.sv
// Memory/writeback stage: issues LW/SW through mem_port_fsm, stalls upstream while waiting,
// and drives the register-file write port and PC redirect toward fetch.
module pipeline4
    import pipeline4_pkg::*;
(
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic [CTRL_WIDTH-1:0]     ctrl_in,
    input  logic                      pc_chg_in,
    input  logic [PC_WIDTH-1:0]       pc_in,
    input  logic                      mem_we_in,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [MEM_WIDTH-1:0]      addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ack,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [MEM_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      stall,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0]     rf_data,
    output logic                      pc_chg_out,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic [CTRL_WIDTH-1:0]     ctrl_out,
    output logic                      mem_err
);
    logic                      is_lw;
    logic                      is_mem;
    logic                      mp_busy;
    logic                      mp_done;
    logic                      ld_p1;
    logic [REG_ADDR_WIDTH-1:0] ld_reg_p1;

    // A store is flagged by mem_we_in; a load by its opcode.
    assign is_lw  = (ctrl_in == OP_LW) && !mem_we_in;
    assign is_mem = is_lw || mem_we_in;
    assign stall  = mp_busy;

    mem_port_fsm u_mem_port (
        .clk_in      (clk_in),
        .RST         (RST),
        .start       (is_mem && !mp_busy),
        .start_wr    (mem_we_in),
        .start_addr  (addr_in),
        .start_wdata (data_in),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (mp_busy),
        .done        (mp_done),
        .mem_err     (mem_err)
    );

    // Stage boundary: execute bundle -> writeback/redirect registers
    always_ff @(posedge clk_in) begin
        if (!RST) begin
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            pc_chg_out <= 1'b0;
            pc_out     <= '0;
            ctrl_out   <= OP_NOP;
            ld_p1      <= 1'b0;
            ld_reg_p1  <= '0;
        end else if (!mp_busy) begin
            pc_chg_out <= pc_chg_in;
            pc_out     <= pc_in;
            if (is_mem) begin
                rf_we     <= 1'b0;
                ctrl_out  <= OP_NOP;
                ld_p1     <= is_lw;
                ld_reg_p1 <= reg_addr_in;
            end else begin
                rf_we    <= op_writes_rf(ctrl_in) && (reg_addr_in != '0);
                rf_addr  <= reg_addr_in;
                rf_data  <= data_in;
                ctrl_out <= ctrl_in;
            end
        end else begin
            pc_chg_out <= 1'b0;
            rf_we      <= 1'b0;
            ctrl_out   <= OP_NOP;
            if (mp_done) begin
                rf_we    <= ld_p1 && (ld_reg_p1 != '0);
                ctrl_out <= ld_p1 ? OP_LW : OP_SW;
                if (ld_p1) begin
                    rf_addr <= ld_reg_p1;
                    rf_data <= mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline4.sv
// Randomized scoreboard bench for pipeline4: driver pushes expected retirements and
// memory requests, a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_pipeline4;
    import pipeline4_pkg::*;

    logic                      clk_in = 1'b0;
    logic                      RST = 1'b0;
    logic [CTRL_WIDTH-1:0]     ctrl_in = OP_NOP;
    logic                      pc_chg_in = 1'b0;
    logic [PC_WIDTH-1:0]       pc_in = '0;
    logic                      mem_we_in = 1'b0;
    logic [DATA_WIDTH-1:0]     data_in = '0;
    logic [MEM_WIDTH-1:0]      addr_in = '0;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_in = '0;
    logic [DATA_WIDTH-1:0]     mem_rdata = '0;
    logic                      mem_ack = 1'b0;
    logic                      mem_req, mem_wr, stall, rf_we, pc_chg_out, mem_err;
    logic [MEM_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata, rf_data;
    logic [REG_ADDR_WIDTH-1:0] rf_addr;
    logic [PC_WIDTH-1:0]       pc_out;
    logic [CTRL_WIDTH-1:0]     ctrl_out;

    always #5 clk_in = ~clk_in;

    pipeline4 dut (
        .clk_in(clk_in), .RST(RST), .ctrl_in(ctrl_in), .pc_chg_in(pc_chg_in), .pc_in(pc_in),
        .mem_we_in(mem_we_in), .data_in(data_in), .addr_in(addr_in), .reg_addr_in(reg_addr_in),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .rf_we(rf_we),
        .rf_addr(rf_addr), .rf_data(rf_data), .pc_chg_out(pc_chg_out), .pc_out(pc_out),
        .ctrl_out(ctrl_out), .mem_err(mem_err)
    );

    typedef struct packed {
        logic                      we;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
        logic [CTRL_WIDTH-1:0]     ctrl;
        logic                      pc_chg;
        logic [PC_WIDTH-1:0]       pc;
    } ev_t;

    typedef struct packed {
        logic                  wr;
        logic [MEM_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mreq_t;

    ev_t   evq[$];
    mreq_t mq[$];
    logic  exp_stall = 1'b0, exp_req = 1'b0, exp_err = 1'b0;
    logic  chk_rst = 1'b0, mon_en = 1'b0, done = 1'b0;
    int    checks = 0, failures = 0;

    // Reference rule: only memory ops, control transfers and NOP leave the register file alone.
    function automatic logic model_writes(input logic [CTRL_WIDTH-1:0] op);
        return !(op inside {OP_LW, OP_SW, OP_JR, OP_JPC, OP_BRFL, OP_RET, OP_NOP});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic issue_op(input logic [CTRL_WIDTH-1:0] op, input logic [REG_ADDR_WIDTH-1:0] rd,
                            input logic [DATA_WIDTH-1:0] data, input logic pcchg,
                            input logic [PC_WIDTH-1:0] pc);
        logic wb;
        @(negedge clk_in);
        ctrl_in = op; mem_we_in = 1'b0; data_in = data; addr_in = MEM_WIDTH'($urandom);
        reg_addr_in = rd; pc_chg_in = pcchg; pc_in = pc;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = DATA_WIDTH'($urandom);
        wb = model_writes(op) && (rd != 0);
        if (wb || op != OP_NOP || pcchg) evq.push_back('{wb, rd, data, op, pcchg, pc});
        @(posedge clk_in); #1;
        exp_stall = 1'b0; exp_req = 1'b0;
    endtask

    // ack_at: WAIT cycle carrying the ack (0 or >MEM_TIMEOUT = never); abort_at: WAIT cycle pulsing reset (0 = none).
    task automatic issue_mem(input logic store, input logic [REG_ADDR_WIDTH-1:0] rd,
                             input logic [DATA_WIDTH-1:0] data, input logic [MEM_WIDTH-1:0] addr,
                             input logic pcchg, input logic [PC_WIDTH-1:0] pc,
                             input int ack_at, input logic [DATA_WIDTH-1:0] rdata, input int abort_at);
        logic completes;
        completes = (ack_at >= 1) && (ack_at <= MEM_TIMEOUT) && (abort_at == 0 || ack_at < abort_at);
        @(negedge clk_in);
        ctrl_in = store ? OP_SW : OP_LW; mem_we_in = store; data_in = data; addr_in = addr;
        reg_addr_in = rd; pc_chg_in = pcchg; pc_in = pc;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = DATA_WIDTH'($urandom);
        mq.push_back('{store, addr, data});
        if (pcchg) evq.push_back('{1'b0, {REG_ADDR_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, OP_NOP, 1'b1, pc});
        if (completes)
            evq.push_back('{!store && (rd != 0), rd, rdata, store ? OP_SW : OP_LW, 1'b0, {PC_WIDTH{1'b0}}});
        @(posedge clk_in); #1;
        exp_stall = 1'b1; exp_req = 1'b1;
        for (int w = 1; w <= MEM_TIMEOUT; w++) begin
            @(negedge clk_in);
            if (w == abort_at) begin
                RST = 1'b0; mem_ack = 1'b0;
                @(posedge clk_in); #1;
                exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; chk_rst = 1'b1;
                @(negedge clk_in);
                RST = 1'b1; ctrl_in = OP_NOP; mem_we_in = 1'b0; pc_chg_in = 1'b0;
                @(posedge clk_in); #1;
                chk_rst = 1'b0;
                break;
            end
            mem_ack = (w == ack_at);
            mem_rdata = (w == ack_at) ? rdata : DATA_WIDTH'($urandom);
            @(posedge clk_in); #1;
            if (w == ack_at || w == MEM_TIMEOUT) begin
                exp_stall = 1'b0; exp_req = 1'b0;
                if (!completes) exp_err = 1'b1;
                break;
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic  prev_req;
        mreq_t held;
        ev_t   e;
        prev_req = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (chk_rst) begin
                    check("rst_rf_we", 32'(rf_we), 32'd0);
                    check("rst_rf_addr", 32'(rf_addr), 32'd0);
                    check("rst_rf_data", 32'(rf_data), 32'd0);
                    check("rst_pc_chg", 32'(pc_chg_out), 32'd0);
                    check("rst_pc_out", 32'(pc_out), 32'd0);
                    check("rst_ctrl_out", 32'(ctrl_out), 32'(OP_NOP));
                    check("rst_mem_addr", 32'(mem_addr), 32'd0);
                    check("rst_mem_wr", 32'(mem_wr), 32'd0);
                end
                check("stall", 32'(stall), 32'(exp_stall));
                check("mem_req", 32'(mem_req), 32'(exp_req));
                check("mem_err", 32'(mem_err), 32'(exp_err));
                if (mem_req && !prev_req) begin
                    if (mq.size() == 0) check("mem_unexpected_req", 32'd1, 32'd0);
                    else begin
                        held = mq.pop_front();
                        check("mem_wr", 32'(mem_wr), 32'(held.wr));
                        check("mem_addr", 32'(mem_addr), 32'(held.addr));
                        if (held.wr) check("mem_wdata", 32'(mem_wdata), 32'(held.wdata));
                    end
                end else if (mem_req) begin
                    check("mem_wr_stable", 32'(mem_wr), 32'(held.wr));
                    check("mem_addr_stable", 32'(mem_addr), 32'(held.addr));
                    if (held.wr) check("mem_wdata_stable", 32'(mem_wdata), 32'(held.wdata));
                end
                prev_req = mem_req;
                if (rf_we || ctrl_out != OP_NOP || pc_chg_out) begin
                    if (evq.size() == 0) check("unexpected_output", 32'd1, 32'd0);
                    else begin
                        e = evq.pop_front();
                        check("rf_we", 32'(rf_we), 32'(e.we));
                        check("ctrl_out", 32'(ctrl_out), 32'(e.ctrl));
                        check("pc_chg_out", 32'(pc_chg_out), 32'(e.pc_chg));
                        if (e.we) begin
                            check("rf_addr", 32'(rf_addr), 32'(e.addr));
                            check("rf_data", 32'(rf_data), 32'(e.data));
                        end
                        if (e.pc_chg) check("pc_out", 32'(pc_out), 32'(e.pc));
                    end
                end
                if (done) begin
                    check("events_outstanding", 32'(evq.size()), 32'd0);
                    check("mem_reqs_outstanding", 32'(mq.size()), 32'd0);
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $finish;
                end
            end
        end
    end

    // Driver
    initial begin
        logic [CTRL_WIDTH-1:0] ops [12];
        int r, ack;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LW_IMM, OP_JR, OP_JPC,
                OP_BRFL, OP_CALL, OP_RET, OP_NOP};
        RST = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        mon_en = 1'b1; chk_rst = 1'b1;
        @(negedge clk_in);
        RST = 1'b1;
        @(posedge clk_in); #1;
        chk_rst = 1'b0;

        issue_op(OP_ADD, 4'd3, 16'h1234, 1'b0, 16'h0000);
        issue_mem(1'b0, 4'd5, 16'h0000, 16'h0040, 1'b0, 16'h0, 3, 16'hBEEF, 0);
        issue_mem(1'b1, 4'd6, 16'h00AA, 16'h0010, 1'b0, 16'h0, 1, 16'h5A5A, 0);
        issue_op(OP_JPC, 4'd2, 16'h7777, 1'b1, 16'h0020);
        issue_mem(1'b0, 4'd7, 16'h0000, 16'h0080, 1'b0, 16'h0, 0, 16'h1111, 0);
        issue_op(OP_ADD, 4'd0, 16'hAAAA, 1'b0, 16'h0000);
        issue_op(OP_LW_IMM, 4'd8, 16'h0F0F, 1'b0, 16'h0000);
        issue_op(OP_CALL, 4'd15, 16'h0102, 1'b1, 16'h0300);
        issue_mem(1'b0, 4'd9, 16'h0000, 16'h00C0, 1'b0, 16'h0, MEM_TIMEOUT, 16'hCAFE, 0);
        issue_mem(1'b0, 4'd10, 16'h0000, 16'h0100, 1'b0, 16'h0, 0, 16'h0, 3);
        issue_op(OP_ADD, 4'd4, 16'h5555, 1'b0, 16'h0000);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 15);
            ack = ($urandom_range(0, 9) == 0) ? 0 :
                  ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT : $urandom_range(1, 4);
            if (r < 12)
                issue_op(ops[r], REG_ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom),
                         1'($urandom_range(0, 1)), PC_WIDTH'($urandom));
            else
                issue_mem(r >= 14, REG_ADDR_WIDTH'($urandom), DATA_WIDTH'($urandom),
                          MEM_WIDTH'($urandom), 1'($urandom_range(0, 1)), PC_WIDTH'($urandom),
                          ack, DATA_WIDTH'($urandom), 0);
        end

        @(negedge clk_in);
        ctrl_in = OP_NOP; mem_we_in = 1'b0; pc_chg_in = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end
endmodule
